dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port, word-wide data memory. It shares the memory between the core load/store unit (port m0) and a DMA/debug master (port m1), and sequences each access onto the memory's single write/read port. Reads use the memory's registered read path, which has one cycle of latency. The arbiter sits between the requesters and the data memory in the multicycle datapath.

---
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the data memory port around dmem_arbiter.
// Latency: none; wires only. The slave modport is the arbiter's view.
// Backpressure: req is held until gnt; read data returns one cycle after gnt.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // requester 0 (core load/store unit)
  logic                  m0_req;
  logic                  m0_we;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_gnt;
  logic                  m0_rvalid;
  logic [DATA_WIDTH-1:0] m0_rdata;
  // requester 1 (DMA / debug)
  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_gnt;
  logic                  m1_rvalid;
  logic [DATA_WIDTH-1:0] m1_rdata;
  // single-port data memory
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rd;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rd
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory (DMEM_ARB_RR_EN: round-robin, else m0 fixed priority).
// Latency: gnt and write same cycle; read data/rvalid one cycle after gnt, next grant one cycle later.
// Backpressure: requesters hold req until gnt; no grants while a read is in flight.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic            clk,
  input logic            rst_n,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t                state_q, state_d;
  logic                  owner_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;

  logic                  gnt0, gnt1, any_gnt;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic                  rvalid0, rvalid1;

`ifdef DMEM_ARB_RR_EN
  // Port favoured on contention: 0 = m0, 1 = m1.
  logic                  prio_q;
`endif

  // Grant selection: only in IDLE, lone requester always wins, contention per policy.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && state_q == IDLE) begin
      if (bus.m0_req && bus.m1_req) begin
`ifdef DMEM_ARB_RR_EN
        gnt0 = ~prio_q;
        gnt1 = prio_q;
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = bus.m0_req;
        gnt1 = bus.m1_req;
      end
    end
  end

  // Winner mux and FSM next state: a granted read parks the FSM for one cycle.
  always_comb begin
    any_gnt   = gnt0 | gnt1;
    win_we    = gnt1 ? bus.m1_we    : bus.m0_we;
    win_addr  = gnt1 ? bus.m1_addr  : bus.m0_addr;
    win_wdata = gnt1 ? bus.m1_wdata : bus.m0_wdata;
    state_d   = state_q;
    case (state_q)
      IDLE:    if (any_gnt && !win_we) state_d = RD_WAIT;
      RD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output drive: memory port follows the winner, otherwise holds last access.
  always_comb begin
    rvalid0       = (state_q == RD_WAIT) && !owner_q;
    rvalid1       = (state_q == RD_WAIT) &&  owner_q;
    bus.m0_gnt    = gnt0;
    bus.m1_gnt    = gnt1;
    bus.m0_rvalid = rvalid0;
    bus.m1_rvalid = rvalid1;
    bus.m0_rdata  = rvalid0 ? bus.mem_rd : m0_rdata_q;
    bus.m1_rdata  = rvalid1 ? bus.mem_rd : m1_rdata_q;
    bus.mem_we    = any_gnt & win_we;
    bus.mem_addr  = any_gnt ? win_addr  : addr_q;
    bus.mem_wdata = any_gnt ? win_wdata : wdata_q;
  end

  // State, read owner, held memory port and held read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (any_gnt) begin
        addr_q  <= win_addr;
        wdata_q <= win_wdata;
        if (!win_we) owner_q <= gnt1;
      end
      if (rvalid0) m0_rdata_q <= bus.mem_rd;
      if (rvalid1) m1_rdata_q <= bus.mem_rd;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Round-robin pointer: after any grant the other port gets priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (any_gnt) begin
      prio_q <= ~gnt1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a word memory model and a reference scoreboard.
// Latency: checks same-cycle gnt/write and read data one cycle after gnt.
// Backpressure: drivers hold req until gnt, each wait bounded by a cycle budget.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Data memory: registered read, updated on the edge after a read is issued.
  logic [DW-1:0] mem [16] = '{default: '0};
  logic [DW-1:0] mem_rd_q = '0;
  assign bus.mem_rd = mem_rd_q;
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
    if ((bus.m0_gnt || bus.m1_gnt) && !bus.mem_we) mem_rd_q <= mem[bus.mem_addr[3:0]];
  end

  // Reference model state
  typedef struct {
    bit            port;
    logic [DW-1:0] data;
  } exp_t;
  exp_t          expq[$];
  logic [DW-1:0] ref_mem [16] = '{default: '0};
  bit            busy = 1'b0;
  bit            busy_port = 1'b0;
`ifdef DMEM_ARB_RR_EN
  bit            favour = 1'b0;
`endif
  logic [DW-1:0] last_rd [2] = '{default: '0};

  // Grant/port checker: policy rules applied to the sampled requests each cycle.
  always @(negedge clk) begin
    logic [1:0] eg;
    bit         w;
    logic       r_we;
    logic [3:0] r_a;
    logic [DW-1:0] r_d;
    if (!rst_n) begin
      check("rst_gnt",    {bus.m1_gnt, bus.m0_gnt}, 0);
      check("rst_rvalid", {bus.m1_rvalid, bus.m0_rvalid}, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_rdata", {bus.m1_rdata, bus.m0_rdata}, 0);
      busy = 1'b0;
`ifdef DMEM_ARB_RR_EN
      favour = 1'b0;
`endif
      expq.delete();
    end else begin
      check("rvalid", {bus.m1_rvalid, bus.m0_rvalid}, busy ? (busy_port ? 2'b10 : 2'b01) : 2'b00);
      eg = 2'b00;
      if (!busy) begin
        if (bus.m0_req && bus.m1_req) begin
`ifdef DMEM_ARB_RR_EN
          eg = favour ? 2'b10 : 2'b01;
`else
          eg = 2'b01;
`endif
        end else begin
          eg = {bus.m1_req, bus.m0_req};
        end
      end
      check("gnt", {bus.m1_gnt, bus.m0_gnt}, eg);
      busy = 1'b0;
      if (eg != 2'b00) begin
        w    = eg[1];
        r_we = w ? bus.m1_we : bus.m0_we;
        r_a  = w ? bus.m1_addr[3:0] : bus.m0_addr[3:0];
        r_d  = w ? bus.m1_wdata : bus.m0_wdata;
        check("mem_we", bus.mem_we, r_we);
        check("mem_addr", bus.mem_addr, {28'd0, r_a});
        if (r_we) begin
          check("mem_wdata", bus.mem_wdata, r_d);
          ref_mem[r_a] = r_d;
        end else begin
          expq.push_back('{port: w, data: ref_mem[r_a]});
          busy      = 1'b1;
          busy_port = w;
        end
`ifdef DMEM_ARB_RR_EN
        favour = ~w;
`endif
      end else begin
        check("mem_we_idle", bus.mem_we, 0);
      end
    end
  end

  // Read-data monitor: pops the scoreboard whenever a port presents rvalid.
  always @(negedge clk) begin
    exp_t e;
    bit   p;
    if (!rst_n) begin
      last_rd[0] = '0;
      last_rd[1] = '0;
    end else begin
      if (bus.m0_rvalid || bus.m1_rvalid) begin
        p = bus.m1_rvalid;
        if (expq.size() == 0) begin
          check("rvalid_without_read", {bus.m1_rvalid, bus.m0_rvalid}, 2'b00);
        end else begin
          e = expq.pop_front();
          check("rvalid_port", p, e.port);
          check("rdata", p ? bus.m1_rdata : bus.m0_rdata, e.data);
          last_rd[p] = e.data;
        end
      end
      if (!bus.m0_rvalid) check("rdata_hold0", bus.m0_rdata, last_rd[0]);
      if (!bus.m1_rvalid) check("rdata_hold1", bus.m1_rdata, last_rd[1]);
    end
  end

  // Issue one access on port p and hold it until granted.
  task automatic do_req(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got;
    got = 1'b0;
    if (p == 0) begin
      bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
    end
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? bus.m0_gnt : bus.m1_gnt;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL gnt_timeout: port %0d got no gnt within 64 cycles", p);
    end
    @(posedge clk);
    #1;
    if (p == 0) bus.m0_req = 1'b0;
    else        bus.m1_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_port(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      idle($urandom_range(0, 2));
      do_req(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
    end
  endtask

  initial begin
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    do_reset();

    // reset asserted while a read is in flight: no rvalid may follow
    do_req(0, 1'b0, 7, 0);
    do_reset();
    idle(2);

    // m0 write then read of the same address
    do_req(0, 1'b1, 5, 32'hDEADBEEF);
    do_req(0, 1'b0, 5, 0);
    idle(2);

    // m1 back-to-back writes, then readback
    for (int i = 0; i < 4; i++) do_req(1, 1'b1, AW'(i), DW'((i + 1) * 32'h11));
    for (int i = 0; i < 4; i++) do_req(1, 1'b0, AW'(i), 0);
    idle(2);

    // continuous write contention from reset
    do_reset();
    fork
      begin for (int k = 0; k < 6; k++) do_req(0, 1'b1, AW'(8 + k), DW'(32'h100 + k)); end
      begin for (int k = 0; k < 6; k++) do_req(1, 1'b1, AW'(8 + k), DW'(32'h200 + k)); end
    join
    idle(2);

    // read of addr 2 blocks a competing write to the same address
    do_reset();
    do_req(1, 1'b1, 2, 32'hA5);
    fork
      do_req(0, 1'b0, 2, 0);
      do_req(1, 1'b1, 2, 32'h5A);
    join
    do_req(0, 1'b0, 2, 0);
    idle(2);

    // randomized mixed traffic on both ports
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    idle(4);
    check("queue_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
